fifo_buffer: RTL



---
 rtl/fifo_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_buffer.sv
// fifo_buffer
// Synchronous FIFO for one transaction lane. It buffers the data stream and
// publishes occupancy status for the downstream flow_control block. Requests
// that cannot be honoured are dropped and reported with one-cycle error pulses.
//
// Ports:
//   clk           - sole clock, all state updates on the rising edge
//   reset         - synchronous, active-high reset (wins over any request)
//   Fifo_wr       - write request, data_in is stored when accepted
//   Fifo_rd       - read request, oldest word moves to data_out when accepted
//   data_in       - write data
//   data_out      - registered read data, holds its value between reads
//   valid_out     - data_out carries a word popped at the last edge
//   Fifo_full     - occupancy == LENGTH
//   Fifo_empty    - occupancy == 0
//   almost_full   - occupancy >= ALMOST_FULL
//   almost_empty  - occupancy <= ALMOST_EMPTY
//   err_overflow  - one-cycle pulse, a write was dropped
//   err_underflow - one-cycle pulse, a read was dropped
module fifo_buffer #(
  parameter int BITNUMBER    = 6,
  parameter int LENGTH       = 4,
  parameter int ALMOST_FULL  = 3,
  parameter int ALMOST_EMPTY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Fifo_wr,
  input  logic                 Fifo_rd,
  input  logic [BITNUMBER-1:0] data_in,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 Fifo_full,
  output logic                 Fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int PTR_W = $clog2(LENGTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] AF_C  = CNT_W'(ALMOST_FULL);
  localparam logic [CNT_W-1:0] AE_C  = CNT_W'(ALMOST_EMPTY);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [BITNUMBER-1:0] memQ [LENGTH];

  logic [PTR_W-1:0]     wptrQ, wptrD;
  logic [PTR_W-1:0]     rptrQ, rptrD;
  logic [CNT_W-1:0]     countQ, countD;
  logic [BITNUMBER-1:0] dataOutQ, dataOutD;
  logic                 validQ, validD;
  logic                 ovfQ, ovfD;
  logic                 unfQ, unfD;

  logic rdOk;
  logic wrOk;

  // Status is a pure decode of the registered occupancy, so flow_control
  // never sees a combinational path from the request inputs.
  assign Fifo_full    = (countQ == LEN_C);
  assign Fifo_empty   = (countQ == '0);
  assign almost_full  = (countQ >= AF_C);
  assign almost_empty = (countQ <= AE_C);

  assign data_out      = dataOutQ;
  assign valid_out     = validQ;
  assign err_overflow  = ovfQ;
  assign err_underflow = unfQ;

  // Accept decisions and next-state values. A write into a full FIFO is
  // still taken when a read frees a slot in the same cycle; a read of an
  // empty FIFO is always dropped, even alongside a write (no fall-through).
  always_comb begin
    rdOk     = Fifo_rd & ~Fifo_empty;
    wrOk     = Fifo_wr & (~Fifo_full | rdOk);

    wptrD    = wptrQ;
    rptrD    = rptrQ;
    countD   = countQ;
    dataOutD = dataOutQ;
    validD   = 1'b0;
    ovfD     = Fifo_wr & ~wrOk;
    unfD     = Fifo_rd & ~rdOk;

    if (wrOk) begin
      wptrD = wptrQ + PTR_ONE;
    end

    if (rdOk) begin
      dataOutD = memQ[rptrQ];
      rptrD    = rptrQ + PTR_ONE;
      validD   = 1'b1;
    end

    case ({wrOk, rdOk})
      2'b10:   countD = countQ + CNT_ONE;
      2'b01:   countD = countQ - CNT_ONE;
      default: countD = countQ;
    endcase
  end

  // Control and output registers; reset takes priority over any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptrQ    <= '0;
      rptrQ    <= '0;
      countQ   <= '0;
      dataOutQ <= '0;
      validQ   <= 1'b0;
      ovfQ     <= 1'b0;
      unfQ     <= 1'b0;
    end else begin
      wptrQ    <= wptrD;
      rptrQ    <= rptrD;
      countQ   <= countD;
      dataOutQ <= dataOutD;
      validQ   <= validD;
      ovfQ     <= ovfD;
      unfQ     <= unfD;
    end
  end

  // Storage has no reset; its contents only become visible through rdOk,
  // which requires a prior accepted write after reset.
  always_ff @(posedge clk) begin
    if (!reset && wrOk) begin
      memQ[wptrQ] <= data_in;
    end
  end

endmodule
